// File: rtl/ttt_button_conditioner_if.sv
// rtl/ttt_button_conditioner_if.sv - raw button inputs and conditioned press/start event outputs
interface ttt_button_conditioner_if #(
  parameter int NUM_BTN = 9
);
  logic [NUM_BTN-1:0] btn_raw;
  logic               start_raw;
  logic               press_valid;
  logic [NUM_BTN-1:0] press_onehot;
  logic [3:0]         press_idx;
  logic               start_pulse;
  logic               any_held;

  // master: the conditioner, which consumes raw buttons and produces events
  modport master (
    input  btn_raw, start_raw,
    output press_valid, press_onehot, press_idx, start_pulse, any_held
  );

  // slave: the button pad plus the game-control block
  modport slave (
    output btn_raw, start_raw,
    input  press_valid, press_onehot, press_idx, start_pulse, any_held
  );
endinterface

// File: rtl/ttt_button_conditioner.sv
// rtl/ttt_button_conditioner.sv - sync, debounce and edge-detect square/start buttons
// Emits one indexed press per physical press, locked out until all squares are released.
module ttt_button_conditioner #(
  parameter int NUM_BTN         = 9,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                   clk,
  input  logic                   reset,
  ttt_button_conditioner_if.master bus
);
  localparam int NIN = NUM_BTN + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [NIN-1:0]     w_raw;
  logic [NIN-1:0]     r_sync1;
  logic [NIN-1:0]     r_sync2;
  logic [NIN-1:0]     r_stable;
  logic [NIN-1:0]     r_stable_d;
  logic [CNT_W-1:0]   r_cnt [NIN];
  logic [NIN-1:0]     w_rise;
  logic               w_any_rise;
  logic [NUM_BTN-1:0] w_first_oh;
  logic [3:0]         w_first_idx;

  logic [0:0]         r_state;
  logic               r_press_valid;
  logic [NUM_BTN-1:0] r_press_onehot;
  logic [3:0]         r_press_idx;
  logic               r_start_pulse;

  // start button rides along as the top bit of every per-input vector
  assign w_raw = {bus.start_raw, bus.btn_raw};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NIN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign w_rise     = r_stable & ~r_stable_d;
  assign w_any_rise = |w_rise[NUM_BTN-1:0];

  // scan downwards so the lowest rising square is the one left standing
  always_comb begin
    w_first_oh  = '0;
    w_first_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_first_oh    = '0;
        w_first_oh[i] = 1'b1;
        w_first_idx   = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_press_valid  <= 1'b0;
      r_press_onehot <= '0;
      r_press_idx    <= '0;
      r_start_pulse  <= 1'b0;
    end else begin
      r_start_pulse  <= w_rise[NUM_BTN];
      r_press_valid  <= 1'b0;
      r_press_onehot <= '0;
      r_press_idx    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_rise) begin
            r_press_valid  <= 1'b1;
            r_press_onehot <= w_first_oh;
            r_press_idx    <= w_first_idx;
            r_state        <= ST_HELD;
          end
        end
        default: begin
          // rises seen here are dropped, not queued
          if (r_stable[NUM_BTN-1:0] == '0) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.press_valid  = r_press_valid;
  assign bus.press_onehot = r_press_onehot;
  assign bus.press_idx    = r_press_idx;
  assign bus.start_pulse  = r_start_pulse;
  assign bus.any_held     = |r_stable[NUM_BTN-1:0];
endmodule

// File: tb/tb_ttt_button_conditioner.sv
// tb/tb_ttt_button_conditioner.sv - self-checking bench for ttt_button_conditioner
module tb_ttt_button_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  ttt_button_conditioner_if #(.NUM_BTN(9)) bus ();

  ttt_button_conditioner #(
    .NUM_BTN(9),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Reference model: a raw-sample history per input; the debounced level flips once the
  // last D synchronised samples (raw delayed two edges) all disagree with it.
  logic [31:0] m_hist [10];
  logic [9:0]  m_stable, m_prev, m_raw, m_rise, m_nxt;
  logic [8:0]  m_sq, m_oh;
  logic [3:0]  m_idx;
  logic        m_held, m_valid, m_start, m_diff;

  always @(posedge clk) begin
    m_raw = {bus.start_raw, bus.btn_raw};
    if (reset) begin
      for (int j = 0; j < 10; j++) m_hist[j] = '0;
      m_stable = '0; m_prev = '0; m_held = 1'b0;
      m_valid = 1'b0; m_oh = '0; m_idx = '0; m_start = 1'b0;
    end else begin
      m_rise = m_stable & ~m_prev;
      m_nxt  = m_stable;
      for (int j = 0; j < 10; j++) begin
        m_hist[j] = {m_hist[j][30:0], m_raw[j]};
        m_diff = 1'b1;
        for (int k = 2; k <= D + 1; k++) if (m_hist[j][k] == m_stable[j]) m_diff = 1'b0;
        if (m_diff) m_nxt[j] = ~m_stable[j];
      end
      m_start = m_rise[9];
      m_sq    = m_rise[8:0];
      m_valid = 1'b0; m_oh = '0; m_idx = '0;
      if (!m_held && m_sq != 0) begin
        m_valid = 1'b1;
        m_oh    = m_sq & (~m_sq + 9'd1);
        for (int k = 0; k < 9; k++) if (m_oh[k]) m_idx = 4'(k);
        m_held  = 1'b1;
      end else if (m_held && m_stable[8:0] == 0) begin
        m_held = 1'b0;
      end
      m_prev   = m_stable;
      m_stable = m_nxt;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.btn_raw = '0; bus.start_raw = 1'b0;
    cyc(3);
    checks++;
    if ({bus.press_valid, bus.press_onehot, bus.press_idx, bus.start_pulse, bus.any_held} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {bus.press_valid, bus.press_onehot, bus.press_idx, bus.start_pulse, bus.any_held});
    end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_single_press();
    bus.btn_raw[4] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      cyc(1);
      checks++;
      if (bus.press_valid !== (n == 7)) begin
        errors++; $display("FAIL single_valid n=%0d: got %b want %b", n, bus.press_valid, n == 7);
      end
      if (n == 7) begin
        checks++;
        if (bus.press_onehot !== 9'h010 || bus.press_idx !== 4'd4) begin
          errors++; $display("FAIL single_data: got %h/%0d want 010/4", bus.press_onehot, bus.press_idx);
        end
      end
    end
    bus.btn_raw = '0;
    cyc(15);
  endtask

  task automatic test_glitch();
    bus.btn_raw[2] = 1'b1;
    cyc(3);
    bus.btn_raw[2] = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cyc(1);
      checks++;
      if (bus.press_valid !== 1'b0 || bus.any_held !== 1'b0) begin
        errors++; $display("FAIL glitch n=%0d: got valid=%b held=%b want 0/0", n, bus.press_valid, bus.any_held);
      end
    end
  endtask

  task automatic test_simultaneous();
    int cnt = 0;
    logic [3:0] idx = '0;
    bus.btn_raw[7] = 1'b1; bus.btn_raw[1] = 1'b1;
    for (int n = 0; n < 14; n++) begin
      cyc(1);
      if (bus.press_valid) begin cnt++; idx = bus.press_idx; end
    end
    checks++;
    if (cnt != 1 || idx !== 4'd1) begin
      errors++; $display("FAIL simultaneous: got %0d pulses idx=%0d want 1 idx=1", cnt, idx);
    end
    bus.btn_raw = '0;
    cyc(15);
  endtask

  task automatic test_lockout();
    int cnt = 0;
    logic [3:0] idx = 4'hf;
    bus.btn_raw[0] = 1'b1;
    cyc(3);
    bus.btn_raw[5] = 1'b1;
    for (int n = 0; n < 15; n++) begin
      cyc(1);
      if (bus.press_valid) begin cnt++; idx = bus.press_idx; end
    end
    checks++;
    if (cnt != 1 || idx !== 4'd0) begin
      errors++; $display("FAIL lockout_first: got %0d pulses idx=%0d want 1 idx=0", cnt, idx);
    end
    bus.btn_raw = '0;
    cyc(10);
    cnt = 0; idx = 4'hf;
    bus.btn_raw[5] = 1'b1;
    for (int n = 0; n < 12; n++) begin
      cyc(1);
      if (bus.press_valid) begin cnt++; idx = bus.press_idx; end
    end
    checks++;
    if (cnt != 1 || idx !== 4'd5) begin
      errors++; $display("FAIL lockout_second: got %0d pulses idx=%0d want 1 idx=5", cnt, idx);
    end
    bus.btn_raw = '0;
    cyc(15);
  endtask

  task automatic test_start();
    int cnt = 0;
    bus.start_raw = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      if (n == 11) bus.start_raw = 1'b0;
      cyc(1);
      if (bus.start_pulse) cnt++;
      checks++;
      if (bus.start_pulse !== (n == 7) || bus.press_valid !== 1'b0) begin
        errors++; $display("FAIL start n=%0d: got start=%b valid=%b want %b/0", n, bus.start_pulse, bus.press_valid, n == 7);
      end
    end
    checks++;
    if (cnt != 1) begin
      errors++; $display("FAIL start_count: got %0d want 1", cnt);
    end
  endtask

  task automatic test_reset_mid_count();
    bus.btn_raw[3] = 1'b1;
    cyc(4);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc(1);
      checks++;
      if ({bus.press_valid, bus.press_onehot, bus.press_idx, bus.start_pulse, bus.any_held} !== 16'h0) begin
        errors++; $display("FAIL reset_mid_outputs n=%0d: got %h want 0", n,
                           {bus.press_valid, bus.press_onehot, bus.press_idx, bus.start_pulse, bus.any_held});
      end
    end
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc(1);
      checks++;
      if (bus.press_valid !== (n == 7) || (n == 7 && bus.press_idx !== 4'd3)) begin
        errors++; $display("FAIL reset_mid_press n=%0d: got valid=%b idx=%0d want %b idx=3",
                           n, bus.press_valid, bus.press_idx, n == 7);
      end
    end
    bus.btn_raw = '0;
    cyc(15);
  endtask

  task automatic test_random();
    logic [15:0] got, want;
    logic        prev_valid = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      cyc(1);
      got  = {bus.press_valid, bus.press_onehot, bus.press_idx, bus.start_pulse, bus.any_held};
      want = {m_valid, m_oh, m_idx, m_start, |m_stable[8:0]};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random_model n=%0d: got %h want %h", n, got, want);
      end
      checks++;
      if (prev_valid && bus.press_valid) begin
        errors++; $display("FAIL back_to_back n=%0d: got valid twice want single", n);
      end
      prev_valid = bus.press_valid;
      if ($urandom_range(0, 5) == 0) bus.btn_raw[$urandom_range(0, 8)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) bus.start_raw = ~bus.start_raw;
      if ($urandom_range(0, 59) == 0) bus.btn_raw = '0;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_raw = '0;
    bus.start_raw = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_lockout();
    test_start();
    test_reset_mid_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
